// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C transmit feeder
// Purpose: feeder state encoding, ACK/NAK bit values and FIFO entry geometry.
// Ports:   none (package).
package i2c_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_CHAIN,
    S_FLUSH,
    S_DRAIN
  } feeder_state_t;

  localparam logic I2C_ACK = 1'b0;
  localparam logic I2C_NAK = 1'b1;

  localparam int BYTE_W  = 8;
  // FIFO entry is {last, data}; the last flag sits in the MSB.
  localparam int ENTRY_W = BYTE_W + 1;

endpackage

// File: rtl/i2c_tx_feeder_if.sv
// rtl/i2c_tx_feeder_if.sv - producer, transmitter and status signals of the feeder
// Purpose: bundles the producer byte stream, the active-low transmitter request
//          interface and the controller status outputs.
// Ports:   master = feeder side (drives in_ready, tx_n, tx_data, status);
//          slave  = environment side (producer, transmitter, controller).
interface i2c_tx_feeder_if #(
  parameter int CNT_W = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             in_last;
  logic             tx_n;
  logic [7:0]       tx_data;
  logic             data_en_n;
  logic             ack_en_n;
  logic             ack_n;
  logic             busy;
  logic             done;
  logic             nak;
  logic             underrun;
  logic [CNT_W-1:0] bytes_sent;

  modport master (
    input  in_valid, in_data, in_last, data_en_n, ack_en_n, ack_n,
    output in_ready, tx_n, tx_data, busy, done, nak, underrun, bytes_sent
  );

  modport slave (
    output in_valid, in_data, in_last, data_en_n, ack_en_n, ack_n,
    input  in_ready, tx_n, tx_data, busy, done, nak, underrun, bytes_sent
  );

endinterface

// File: rtl/i2c_byte_fifo.sv
// rtl/i2c_byte_fifo.sv - synchronous FIFO holding {last, data} entries
// Purpose: buffers producer bytes; head is read straight from the storage
//          array at the read pointer, so a push becomes visible the cycle after.
// Ports:   clk, rstn (sync, active-low); i_push/i_wdata write side;
//          i_pop read side; o_head, o_full, o_empty status.
module i2c_byte_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8   // power of two, >= 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_pop;
  logic             w_do_push;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_do_pop  = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot, so a push at full is still safe.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  assign o_head = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/i2c_tx_feeder.sv
// rtl/i2c_tx_feeder.sv - byte feeder in front of the I2C byte transmitter
// Purpose: queues producer bytes, hands them to the transmitter over the
//          active-low request interface, tracks ACK/NAK per byte and reports
//          done / nak / underrun pulses plus a saturating ACKed-byte count.
// Ports:   clk, rstn (sync, active-low); bus (i2c_tx_feeder_if.master):
//          in_valid/in_ready/in_data/in_last producer stream,
//          tx_n/tx_data/data_en_n/ack_en_n/ack_n transmitter handshake,
//          busy/done/nak/underrun/bytes_sent controller status.
module i2c_tx_feeder
  import i2c_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rstn,
  i2c_tx_feeder_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  feeder_state_t      r_state;
  feeder_state_t      w_next;
  logic               r_cur_last;
  logic               w_cur_last_nxt;
  logic               r_done;
  logic               r_nak;
  logic               r_underrun;
  logic               w_done_nxt;
  logic               w_nak_nxt;
  logic               w_underrun_nxt;
  logic               w_count;
  logic [CNT_W-1:0]   r_bytes_sent;
  logic               w_pop;
  logic               w_push;
  logic [ENTRY_W-1:0] w_head;
  logic               w_full;
  logic               w_empty;
  logic               w_tx_req;

  assign w_push       = bus.in_valid & ~w_full;
  assign bus.in_ready = ~w_full;

  i2c_byte_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_wdata ({bus.in_last, bus.in_data}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_cur_last   <= 1'b0;
      r_done       <= 1'b0;
      r_nak        <= 1'b0;
      r_underrun   <= 1'b0;
      r_bytes_sent <= '0;
    end else begin
      r_state    <= w_next;
      r_cur_last <= w_cur_last_nxt;
      r_done     <= w_done_nxt;
      r_nak      <= w_nak_nxt;
      r_underrun <= w_underrun_nxt;
      if (w_count && (r_bytes_sent != CNT_MAX)) begin
        r_bytes_sent <= r_bytes_sent + CNT_ONE;
      end
    end
  end

  always_comb begin
    w_next         = r_state;
    w_cur_last_nxt = r_cur_last;
    w_pop          = 1'b0;
    w_done_nxt     = 1'b0;
    w_nak_nxt      = 1'b0;
    w_underrun_nxt = 1'b0;
    w_count        = 1'b0;
    case (r_state)
      S_IDLE: begin
        // data_en_n high means the transmitter has latched tx_data and started.
        if (!w_empty && bus.data_en_n) begin
          w_pop          = 1'b1;
          w_cur_last_nxt = w_head[ENTRY_W-1];
          w_next         = S_SEND;
        end
      end
      S_SEND: begin
        if (!bus.ack_en_n) begin
          case (bus.ack_n)
            I2C_ACK: begin
              w_count = 1'b1;
              if (r_cur_last) begin
                w_done_nxt = 1'b1;
                w_next     = S_DRAIN;
              end else if (w_empty) begin
                w_underrun_nxt = 1'b1;
                w_next         = S_DRAIN;
              end else begin
                w_next = S_CHAIN;
              end
            end
            I2C_NAK: begin
              w_nak_nxt = 1'b1;
              // Remaining bytes of the aborted transfer must be discarded.
              w_next    = r_cur_last ? S_DRAIN : S_FLUSH;
            end
            default: w_next = r_state;
          endcase
        end
      end
      S_CHAIN: begin
        // The transmitter reloads tx_data while ack_en_n is released.
        if (bus.ack_en_n) begin
          w_pop          = 1'b1;
          w_cur_last_nxt = w_head[ENTRY_W-1];
          w_next         = S_SEND;
        end
      end
      S_FLUSH: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_head[ENTRY_W-1]) w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!bus.data_en_n && bus.ack_en_n) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request depends on registered state and FIFO flags only.
  assign w_tx_req       = ((r_state == S_IDLE) && !w_empty) || (r_state == S_CHAIN);
  assign bus.tx_n       = ~w_tx_req;
  assign bus.tx_data    = w_empty ? 8'h00 : w_head[BYTE_W-1:0];
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.done       = r_done;
  assign bus.nak        = r_nak;
  assign bus.underrun   = r_underrun;
  assign bus.bytes_sent = r_bytes_sent;

endmodule

// File: tb/tb_i2c_tx_feeder.sv
// tb/tb_i2c_tx_feeder.sv - self-checking bench for i2c_tx_feeder
module tb_i2c_tx_feeder;
  import i2c_pkg::*;

  localparam int DEPTH   = 8;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // abstract transfer phases of the reference model
  localparam int PH_WAIT   = 0;  // no transfer; next queued byte is offered
  localparam int PH_BYTE   = 1;  // a byte is on the bus awaiting ACK/NAK
  localparam int PH_NEXT   = 2;  // ACKed, next byte of the transfer offered
  localparam int PH_DISCARD = 3; // aborted, dropping bytes up to a last byte
  localparam int PH_SETTLE = 4;  // waiting for the transmitter to go idle

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  i2c_tx_feeder_if #(.CNT_W(CNT_W)) bus ();

  i2c_tx_feeder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // transmitter controls (written by the main sequence)
  bit tx_enable = 1'b0;
  int tx_delay  = 2;
  bit rand_nak  = 1'b0;
  int nak_at    = -1;
  // transmitter observations
  logic [7:0] cap_log[$];
  int n_chain = 0;
  int n_ack   = 0;
  // pulse observations
  int n_done = 0;
  int n_nak  = 0;
  int n_under = 0;

  // reference model state
  logic [8:0] m_q[$];
  int   m_phase = PH_WAIT;
  logic m_cur_last = 1'b0;
  int   m_sent = 0;
  logic m_done = 1'b0;
  logic m_nak = 1'b0;
  logic m_under = 1'b0;
  bit   m_live = 1'b0;

  // Transmitter model: starts on tx_n low, shifts a few cycles, reports ACK/NAK,
  // reloads if the feeder re-requests right after an ACK.
  initial begin
    int  cnt;
    bit  shifting;
    bit  ack_phase;
    bit  give_nak;
    cnt = 0; shifting = 0; ack_phase = 0;
    bus.data_en_n = 1'b0;
    bus.ack_en_n  = 1'b1;
    bus.ack_n     = 1'b1;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        shifting = 0; ack_phase = 0;
        bus.data_en_n = 1'b0; bus.ack_en_n = 1'b1; bus.ack_n = 1'b1;
      end else if (ack_phase) begin
        ack_phase = 0;
        bus.ack_en_n = 1'b1;
        bus.ack_n    = 1'b1;
        if (bus.tx_n == 1'b0) begin
          cap_log.push_back(bus.tx_data);
          n_chain++;
          bus.data_en_n = 1'b1;
          shifting = 1;
          cnt = (tx_delay == 0) ? int'($urandom_range(0, 3)) : tx_delay;
        end else begin
          bus.data_en_n = 1'b0;
        end
      end else if (shifting) begin
        if (cnt > 0) cnt--;
        else begin
          shifting = 0;
          ack_phase = 1;
          give_nak = rand_nak ? ($urandom_range(0, 7) == 0) : ((cap_log.size() - 1) == nak_at);
          if (!give_nak) n_ack++;
          bus.data_en_n = 1'b0;
          bus.ack_en_n  = 1'b0;
          bus.ack_n     = give_nak ? I2C_NAK : I2C_ACK;
        end
      end else if (tx_enable && bus.tx_n == 1'b0) begin
        cap_log.push_back(bus.tx_data);
        bus.data_en_n = 1'b1;
        shifting = 1;
        cnt = (tx_delay == 0) ? int'($urandom_range(0, 3)) : tx_delay;
      end else begin
        bus.data_en_n = 1'b0;
        bus.ack_en_n  = 1'b1;
      end
    end
  end

  // Reference model: byte queue plus transfer phase, advanced from the inputs
  // seen at each rising edge.
  initial begin
    int         pre_n;
    bit         accept;
    logic [8:0] e;
    forever begin
      @(posedge clk);
      if (!rstn) begin
        m_q.delete();
        m_phase = PH_WAIT; m_cur_last = 1'b0; m_sent = 0;
        m_done = 1'b0; m_nak = 1'b0; m_under = 1'b0;
        m_live = 1'b1;
      end else begin
        pre_n  = m_q.size();
        accept = bus.in_valid && (pre_n < DEPTH);
        m_done = 1'b0; m_nak = 1'b0; m_under = 1'b0;
        if (m_phase == PH_WAIT) begin
          if (pre_n > 0 && bus.data_en_n) begin
            e = m_q.pop_front(); m_cur_last = e[8]; m_phase = PH_BYTE;
          end
        end else if (m_phase == PH_BYTE) begin
          if (!bus.ack_en_n) begin
            if (bus.ack_n == I2C_ACK) begin
              if (m_sent < CNT_MAX) m_sent++;
              if (m_cur_last) begin m_done = 1'b1; m_phase = PH_SETTLE; end
              else if (pre_n == 0) begin m_under = 1'b1; m_phase = PH_SETTLE; end
              else m_phase = PH_NEXT;
            end else begin
              m_nak = 1'b1;
              m_phase = m_cur_last ? PH_SETTLE : PH_DISCARD;
            end
          end
        end else if (m_phase == PH_NEXT) begin
          if (bus.ack_en_n) begin
            e = m_q.pop_front(); m_cur_last = e[8]; m_phase = PH_BYTE;
          end
        end else if (m_phase == PH_DISCARD) begin
          if (pre_n > 0) begin
            e = m_q.pop_front();
            if (e[8]) m_phase = PH_SETTLE;
          end
        end else begin
          if (!bus.data_en_n && bus.ack_en_n) m_phase = PH_WAIT;
        end
        if (accept) m_q.push_back({bus.in_last, bus.in_data});
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  initial begin
    bit exp_req;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) n_done++;
      if (bus.nak === 1'b1) n_nak++;
      if (bus.underrun === 1'b1) n_under++;
      if (m_live) begin
        exp_req = ((m_phase == PH_WAIT) && (m_q.size() > 0)) || (m_phase == PH_NEXT);
        check("tx_n", bus.tx_n, !exp_req);
        if (exp_req && m_q.size() > 0) check("tx_data", bus.tx_data, m_q[0][7:0]);
        check("busy", bus.busy, m_phase != PH_WAIT);
        check("in_ready", bus.in_ready, m_q.size() < DEPTH);
        check("done", bus.done, m_done);
        check("nak", bus.nak, m_nak);
        check("underrun", bus.underrun, m_under);
        check("bytes_sent", bus.bytes_sent, m_sent);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: no finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic push(input logic [7:0] d, input logic l);
    int g;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_last = l;
    g = 0;
    while (bus.in_ready !== 1'b1 && g < 2000) begin @(negedge clk); g++; end
    check("push_accepted", g < 2000, 1);
    @(posedge clk);
  endtask

  task automatic idle_in();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; tx_enable = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic wait_quiet(input string name);
    int q;
    int g;
    q = 0; g = 0;
    while (q < 4 && g < 2000) begin
      @(negedge clk); g++;
      if (bus.busy == 1'b0 && bus.tx_n == 1'b1) q++; else q = 0;
    end
    check(name, q >= 4, 1);
  endtask

  initial begin
    int base, bd, bn, bu, bc, a0, g;
    bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.in_last = 1'b0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_n", bus.tx_n, 1);
    check("rst_tx_data", bus.tx_data, 8'h00);
    check("rst_busy", bus.busy, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_bytes_sent", bus.bytes_sent, 0);
    rstn = 1'b1;

    // single byte, ACK
    base = cap_log.size(); bd = n_done;
    push(8'hA5, 1'b1); idle_in();
    tx_enable = 1'b1;
    wait_quiet("t1_settle");
    check("t1_cap_n", cap_log.size() - base, 1);
    check("t1_cap0", cap_log[base], 8'hA5);
    check("t1_done", n_done - bd, 1);
    check("t1_sent", bus.bytes_sent, 1);

    // three chained bytes
    do_reset();
    base = cap_log.size(); bd = n_done; bc = n_chain;
    push(8'h11, 1'b0); push(8'h22, 1'b0); push(8'h33, 1'b1); idle_in();
    tx_enable = 1'b1;
    wait_quiet("t2_settle");
    check("t2_cap_n", cap_log.size() - base, 3);
    check("t2_cap0", cap_log[base], 8'h11);
    check("t2_cap1", cap_log[base+1], 8'h22);
    check("t2_cap2", cap_log[base+2], 8'h33);
    check("t2_chain", n_chain - bc, 2);
    check("t2_done", n_done - bd, 1);
    check("t2_sent", bus.bytes_sent, 3);

    // NAK on the second byte
    do_reset();
    base = cap_log.size(); bd = n_done; bn = n_nak;
    nak_at = base + 1;
    push(8'h01, 1'b0); push(8'h02, 1'b0); push(8'h03, 1'b1); idle_in();
    tx_enable = 1'b1;
    wait_quiet("t3_settle");
    nak_at = -1;
    check("t3_cap_n", cap_log.size() - base, 2);
    check("t3_cap1", cap_log[base+1], 8'h02);
    check("t3_nak", n_nak - bn, 1);
    check("t3_done", n_done - bd, 0);
    check("t3_sent", bus.bytes_sent, 1);
    check("t3_empty", bus.in_ready, 1);

    // underrun: two bytes with no last flag
    do_reset();
    bd = n_done; bu = n_under;
    push(8'hAA, 1'b0); push(8'hBB, 1'b0); idle_in();
    tx_enable = 1'b1;
    wait_quiet("t4_settle");
    check("t4_under", n_under - bu, 1);
    check("t4_done", n_done - bd, 0);
    check("t4_sent", bus.bytes_sent, 2);

    // fill to full, then drain while still pushing
    do_reset();
    base = cap_log.size(); bd = n_done;
    for (int i = 0; i < DEPTH; i++) push(8'(i), 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 8'(DEPTH); bus.in_last = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_full_ready", bus.in_ready, 0);
    tx_enable = 1'b1;
    for (int i = DEPTH; i < 2 * DEPTH; i++) push(8'(i), 1'b1);
    idle_in();
    wait_quiet("t5_settle");
    check("t5_cap_n", cap_log.size() - base, 2 * DEPTH);
    for (int i = 0; i < 2 * DEPTH; i++) check("t5_order", cap_log[base+i], i);
    check("t5_done", n_done - bd, 2 * DEPTH);
    check("t5_sent", bus.bytes_sent, 2 * DEPTH);

    // reset while a byte is on the bus and three are queued
    do_reset();
    tx_delay = 6;
    push(8'h10, 1'b0); push(8'h20, 1'b0); push(8'h30, 1'b0); push(8'h40, 1'b1); idle_in();
    base = cap_log.size();
    tx_enable = 1'b1;
    g = 0;
    while (cap_log.size() == base && g < 200) begin @(negedge clk); g++; end
    check("t6_started", g < 200, 1);
    @(negedge clk);
    rstn = 1'b0; tx_enable = 1'b0;
    @(negedge clk);
    check("t6_tx_n", bus.tx_n, 1);
    check("t6_busy", bus.busy, 0);
    check("t6_in_ready", bus.in_ready, 1);
    check("t6_sent", bus.bytes_sent, 0);
    @(negedge clk);
    rstn = 1'b1; tx_enable = 1'b1;
    repeat (20) @(negedge clk);
    check("t6_no_more", cap_log.size() - base, 1);
    tx_delay = 0;

    // randomized traffic with random NAKs, long enough to saturate the counter
    do_reset();
    a0 = n_ack;
    rand_nak = 1'b1; tx_enable = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      bus.in_valid = (i < 2500) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 5) == 0);
      bus.in_data  = 8'($urandom_range(0, 255));
      bus.in_last  = ($urandom_range(0, 4) == 0);
    end
    idle_in();
    rand_nak = 1'b0;
    wait_quiet("rand_settle");
    check("rand_sat_reached", (n_ack - a0) >= CNT_MAX, 1);
    check("rand_sent", bus.bytes_sent, ((n_ack - a0) > CNT_MAX) ? CNT_MAX : (n_ack - a0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
